// File: rtl/seven_segment_fun_pkg.sv
// seven_segment_fun_pkg: shared constants for the seven_segment_fun tile.
//   SEG_A..SEG_G  active-high segment bits as laid out on uo_out[6:0]
//   ANIM_*        animation indices as mirrored on uio_out[2:0]
//   FRAME_CNT     number of frames in each animation, indexed by anim
//   SPEED_RST     playback speed after reset
package seven_segment_fun_pkg;

  localparam logic [6:0] SEG_A = 7'h01;
  localparam logic [6:0] SEG_B = 7'h02;
  localparam logic [6:0] SEG_C = 7'h04;
  localparam logic [6:0] SEG_D = 7'h08;
  localparam logic [6:0] SEG_E = 7'h10;
  localparam logic [6:0] SEG_F = 7'h20;
  localparam logic [6:0] SEG_G = 7'h40;

  localparam logic [2:0] ANIM_CW     = 3'd0;
  localparam logic [2:0] ANIM_CCW    = 3'd1;
  localparam logic [2:0] ANIM_FIG8   = 3'd2;
  localparam logic [2:0] ANIM_HEX    = 3'd3;
  localparam logic [2:0] ANIM_FILL   = 3'd4;
  localparam logic [2:0] ANIM_BLINK  = 3'd5;
  localparam logic [2:0] ANIM_SNAKE  = 3'd6;
  localparam logic [2:0] ANIM_BOUNCE = 3'd7;

  localparam logic [4:0] FRAME_CNT [8] = '{5'd6, 5'd6, 5'd8, 5'd16,
                                           5'd7, 5'd2, 5'd6, 5'd4};

  localparam logic [2:0] SPEED_RST = 3'd4;

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// seven_seg_hex_decoder: 4-bit value to active-high 7-segment pattern, 0..F.
//   val  in   4  hex digit
//   seg  out  7  segments a..g ([0]=a)
module seven_seg_hex_decoder (
  input  logic [3:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (val)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_segment_fun.sv
// seven_segment_fun: TinyTapeout tile, button-selectable 7-segment animations.
//   clk, rst_n  clock, synchronous active-low reset
//   ena         tile enable (ignored)
//   ui_in[3:0]  btn1 anim+, btn2 anim-, btn3 speed+, btn4 speed-
//   uo_out      [6:0] segments a..g active-high, [7] decimal point
//   uio_in      unused
//   uio_out     [2:0] anim, [5:3] speed, [7:6] zero
//   uio_oe      constant 8'h3F
// Step period is 2^(PRESC_BASE+7-speed) clocks.
// Build option DP_HEARTBEAT_EN: decimal point toggles on every step tick and
// clears on reset or animation change; otherwise it stays 0.
module seven_segment_fun
  import seven_segment_fun_pkg::*;
#(
  parameter int PRESC_BASE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = PRESC_BASE + 7;

  logic          unused_in;
  logic [3:0]    sync1, sync2, prev;
  logic [3:0]    press;
  logic          anim_inc, anim_dec, anim_chg, spd_inc, spd_dec;
  logic [2:0]    anim, speed;
  logic [3:0]    frame;
  logic [4:0]    frame_last;
  logic [CW-1:0] presc, presc_last;
  logic          tick;
  logic          dp;
  logic [6:0]    seg, hex_seg;

  assign unused_in = ^{ena, ui_in[7:4], uio_in};

  // Press is a rising edge of the synchronized level.
  assign press    = sync2 & ~prev;
  // Opposing presses in the same cycle cancel out.
  assign anim_inc = press[0] & ~press[1];
  assign anim_dec = press[1] & ~press[0];
  assign anim_chg = anim_inc | anim_dec;
  assign spd_inc  = press[2] & ~press[3];
  assign spd_dec  = press[3] & ~press[2];

  // All-ones shifted right by speed gives 2^(CW-speed)-1. Using >= lets a
  // speed-up with the count already past the new limit tick right away.
  assign presc_last = {CW{1'b1}} >> speed;
  assign tick       = presc >= presc_last;
  assign frame_last = FRAME_CNT[anim] - 5'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      anim  <= ANIM_CW;
      speed <= SPEED_RST;
      frame <= '0;
      presc <= '0;
    end else begin
      sync1 <= ui_in[3:0];
      sync2 <= sync1;
      prev  <= sync2;

      if (anim_inc)      anim <= anim + 3'd1;
      else if (anim_dec) anim <= anim - 3'd1;

      if (spd_inc && speed != 3'd7)      speed <= speed + 3'd1;
      else if (spd_dec && speed != 3'd0) speed <= speed - 3'd1;

      if (anim_chg) begin
        frame <= '0;
        presc <= '0;
      end else if (tick) begin
        presc <= '0;
        frame <= ({1'b0, frame} == frame_last) ? 4'd0 : frame + 4'd1;
      end else begin
        presc <= presc + CW'(1);
      end
    end
  end

`ifdef DP_HEARTBEAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        dp <= 1'b0;
    else if (anim_chg) dp <= 1'b0;
    else if (tick)     dp <= ~dp;
  end
`else
  assign dp = 1'b0;
`endif

  seven_seg_hex_decoder u_hex (
    .val (frame),
    .seg (hex_seg)
  );

  always_comb begin
    seg = 7'h00;
    case ({anim, frame})
      {ANIM_CW, 4'd0}:     seg = SEG_A;
      {ANIM_CW, 4'd1}:     seg = SEG_B;
      {ANIM_CW, 4'd2}:     seg = SEG_C;
      {ANIM_CW, 4'd3}:     seg = SEG_D;
      {ANIM_CW, 4'd4}:     seg = SEG_E;
      {ANIM_CW, 4'd5}:     seg = SEG_F;
      {ANIM_CCW, 4'd0}:    seg = SEG_A;
      {ANIM_CCW, 4'd1}:    seg = SEG_F;
      {ANIM_CCW, 4'd2}:    seg = SEG_E;
      {ANIM_CCW, 4'd3}:    seg = SEG_D;
      {ANIM_CCW, 4'd4}:    seg = SEG_C;
      {ANIM_CCW, 4'd5}:    seg = SEG_B;
      {ANIM_FIG8, 4'd0}:   seg = SEG_A;
      {ANIM_FIG8, 4'd1}:   seg = SEG_B;
      {ANIM_FIG8, 4'd2}:   seg = SEG_G;
      {ANIM_FIG8, 4'd3}:   seg = SEG_E;
      {ANIM_FIG8, 4'd4}:   seg = SEG_D;
      {ANIM_FIG8, 4'd5}:   seg = SEG_C;
      {ANIM_FIG8, 4'd6}:   seg = SEG_G;
      {ANIM_FIG8, 4'd7}:   seg = SEG_F;
      {ANIM_FILL, 4'd0}:   seg = SEG_A;
      {ANIM_FILL, 4'd1}:   seg = SEG_A | SEG_B;
      {ANIM_FILL, 4'd2}:   seg = SEG_A | SEG_B | SEG_C;
      {ANIM_FILL, 4'd3}:   seg = SEG_A | SEG_B | SEG_C | SEG_D;
      {ANIM_FILL, 4'd4}:   seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E;
      {ANIM_FILL, 4'd5}:   seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
      {ANIM_FILL, 4'd6}:   seg = 7'h00;
      {ANIM_BLINK, 4'd0}:  seg = 7'h7F;
      {ANIM_BLINK, 4'd1}:  seg = 7'h00;
      {ANIM_SNAKE, 4'd0}:  seg = SEG_A | SEG_B;
      {ANIM_SNAKE, 4'd1}:  seg = SEG_B | SEG_C;
      {ANIM_SNAKE, 4'd2}:  seg = SEG_C | SEG_D;
      {ANIM_SNAKE, 4'd3}:  seg = SEG_D | SEG_E;
      {ANIM_SNAKE, 4'd4}:  seg = SEG_E | SEG_F;
      {ANIM_SNAKE, 4'd5}:  seg = SEG_F | SEG_A;
      {ANIM_BOUNCE, 4'd0}: seg = SEG_A;
      {ANIM_BOUNCE, 4'd1}: seg = SEG_G;
      {ANIM_BOUNCE, 4'd2}: seg = SEG_D;
      {ANIM_BOUNCE, 4'd3}: seg = SEG_G;
      default:             seg = (anim == ANIM_HEX) ? hex_seg : 7'h00;
    endcase
  end

  assign uo_out  = {dp, seg};
  assign uio_out = {2'b00, speed, anim};
  assign uio_oe  = 8'h3F;

endmodule

// File: tb/tb_seven_segment_fun.sv
// Scoreboard bench for seven_segment_fun (PRESC_BASE=2). The stimulus process
// advances a behavioural model once per clock edge and queues the outputs
// that edge should produce; an independent monitor pops and compares on the
// falling edge.
module tb_seven_segment_fun;

  localparam int PB = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  seven_segment_fun #(.PRESC_BASE(PB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- reference model ----------------
  // Animations written as lit-segment letters, frames separated by spaces,
  // '-' for a blank frame.
  string      anim_str [8];
  logic [6:0] tab [8][16];
  int         nfr [8];

  int         m_anim, m_speed, m_frame, m_cnt;
  logic       m_dp;
  logic [3:0] lv [3];   // pin levels seen at the last three edges, [0] newest

  function automatic void build_tables();
    anim_str[0] = "a b c d e f";
    anim_str[1] = "a f e d c b";
    anim_str[2] = "a b g e d c g f";
    anim_str[3] = "abcdef bc abdeg abcdg bcfg acdfg acdefg abc abcdefg abcdfg abcefg cdefg adef bcdeg adefg aefg";
    anim_str[4] = "a ab abc abcd abcde abcdef -";
    anim_str[5] = "abcdefg -";
    anim_str[6] = "ab bc cd de ef fa";
    anim_str[7] = "a g d g";
    for (int a = 0; a < 8; a++) begin
      int f;
      f = 0;
      for (int k = 0; k < 16; k++) tab[a][k] = 7'h00;
      for (int i = 0; i < anim_str[a].len(); i++) begin
        byte ch;
        ch = anim_str[a].getc(i);
        if (ch == 8'h20) f++;
        else if (ch >= 8'h61 && ch <= 8'h67) tab[a][f] = tab[a][f] | (7'd1 << (ch - 8'h61));
      end
      nfr[a] = f + 1;
    end
  endfunction

  function automatic void model_reset();
    m_anim = 0; m_speed = 4; m_frame = 0; m_cnt = 0; m_dp = 1'b0;
    for (int i = 0; i < 3; i++) lv[i] = 4'h0;
  endfunction

  // One rising edge: a level first seen at edge k becomes a press at edge k+2
  // when the level seen one edge earlier was low.
  task automatic model_edge();
    exp_t e;
    if (!rst_n) begin
      model_reset();
    end else begin
      logic [3:0] p;
      int period;
      bit ach, tk;
      p      = lv[1] & ~lv[2];
      period = 1 << (PB + 7 - m_speed);
      tk     = (m_cnt >= period - 1);
      ach    = p[0] ^ p[1];
      if (p[0] && !p[1]) m_anim = (m_anim + 1) % 8;
      if (p[1] && !p[0]) m_anim = (m_anim + 7) % 8;
      if (p[2] && !p[3] && m_speed < 7) m_speed++;
      if (p[3] && !p[2] && m_speed > 0) m_speed--;
      if (ach) begin
        m_frame = 0; m_cnt = 0; m_dp = 1'b0;
      end else if (tk) begin
        m_frame = (m_frame + 1) % nfr[m_anim];
        m_cnt   = 0;
`ifdef DP_HEARTBEAT_EN
        m_dp    = ~m_dp;
`endif
      end else begin
        m_cnt++;
      end
      lv[2] = lv[1];
      lv[1] = lv[0];
      lv[0] = ui_in[3:0];
    end
    e.uo  = {m_dp, tab[m_anim][m_frame]};
    e.uio = 8'((m_speed << 3) | m_anim);
    e.oe  = 8'h3F;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got 0x%02h expected 0x%02h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("uo_out", uo_out, e.uo);
      chk("uio_out", uio_out, e.uio);
      chk("uio_oe", uio_oe, e.oe);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int b);
    ui_in[b] = 1'b1;
    cycles(4);
    ui_in[b] = 1'b0;
    cycles(4);
  endtask

  initial begin
    build_tables();
    model_reset();

    // reset held for five clocks
    rst_n = 1'b0;
    cycles(5);
    rst_n = 1'b1;

    // anim 0 at speed 4: one full revolution plus wrap
    cycles(7 * 32 + 5);

    // btn2 from anim 0 wraps to 7 (bounce)
    press(1);
    cycles(4 * 32 + 4);

    // speed up to saturation, then down to saturation
    repeat (5) press(2);
    cycles(40);
    repeat (10) press(3);
    cycles(1100);
    repeat (4) press(2);

    // 7 -> 0 -> 1 -> 2 -> 3: hex count over all sixteen digits
    repeat (4) press(0);
    cycles(17 * 32 + 4);

    // a held button counts once
    ui_in[0] = 1'b1;
    cycles(100);
    ui_in[0] = 1'b0;
    cycles(10);

    // opposing presses in the same cycle cancel
    ui_in[1:0] = 2'b11;
    cycles(6);
    ui_in[1:0] = 2'b00;
    cycles(40);

    // button high across reset release counts as one press
    rst_n = 1'b0;
    ui_in[0] = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
    ui_in[0] = 1'b0;
    cycles(10);

    // random buttons, garbage on unused pins, occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ui_in[3:0] = ui_in[3:0] ^ (4'd1 << $urandom_range(0, 3));
      ui_in[7:4] = 4'($urandom);
      uio_in     = 8'($urandom);
      ena        = 1'($urandom);
      rst_n      = ($urandom_range(0, 499) != 0);
      step();
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
